// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported backend memory between the fetch stage (instruction
// reads) and the memory stage (data reads/writes).  One access is in flight at
// a time.  The data port normally wins, but a starvation counter forces a fetch
// grant after STARVE_MAX consecutive losses.  A watchdog aborts any access that
// has waited TIMEOUT busy cycles without an ack, so the pipeline cannot hang.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   i_req/i_addr          fetch read request, held until i_valid
//   i_rdata/i_valid       fetch read data, one-cycle completion pulse
//   d_req/d_we/d_addr/    memory-stage request, held until d_valid
//   d_wdata
//   d_rdata/d_valid       load data, one-cycle completion pulse
//   mem_req/mem_we/       backend request; mem_req held up to and including
//   mem_addr/mem_wdata    the ack cycle
//   mem_rdata/mem_ack     backend read data and one-cycle completion
//   stall_f/stall_m       request outstanding and not completing this cycle
//   timeout_err           sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT    = 64,  // >= 2
    parameter int STARVE_MAX = 4    // >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    // backend
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // hazard / status
    output logic        stall_f,
    output logic        stall_m,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   to_cnt;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     i_rdata_q;
    logic [31:0]     d_rdata_q;

    logic busy;
    logic ack;      // normal completion this cycle
    logic abort;    // watchdog expiry this cycle (ack absent)
    logic done;
    logic grant_i;
    logic grant_d;
    logic starved;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state, arbitration and completion outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        // An ack on the last allowed cycle is a normal completion, so the
        // abort term requires mem_ack low.
        ack       = busy & mem_ack;
        abort     = busy & ~mem_ack & (to_cnt == TW'(TIMEOUT - 1));
        done      = ack | abort;
        starved   = (starve_cnt == SW'(STARVE_MAX));
        grant_i   = (state == IDLE) & i_req & (starved | ~d_req);
        grant_d   = (state == IDLE) & d_req & ~grant_i;

        i_valid   = (state == BUSY_I) & done;
        d_valid   = (state == BUSY_D) & done;

        // Read data is forwarded straight from the backend in the ack
        // cycle; the capture register supplies it afterwards.
        i_rdata   = i_rdata_q;
        if (state == BUSY_I) begin
            if (ack)        i_rdata = mem_rdata;
            else if (abort) i_rdata = 32'hFFFF_FFFF;
        end

        d_rdata   = d_rdata_q;
        if (state == BUSY_D) begin
            if (ack && !mem_we) d_rdata = mem_rdata;
            else if (abort)     d_rdata = 32'hFFFF_FFFF;
        end

        stall_f   = i_req & ~i_valid;
        stall_m   = d_req & ~d_valid;

        case (state)
            IDLE: begin
                if (grant_i)      state_nxt = BUSY_I;
                else if (grant_d) state_nxt = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Backend request registers, watchdog and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= 32'h0;
            end else if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end

            if (done) begin
                mem_req <= 1'b0;
                to_cnt  <= '0;
            end else if (busy) begin
                to_cnt  <= to_cnt + TW'(1);
            end

            if (abort)
                timeout_err <= 1'b1;

            // Only genuine read data is captured; writes leave d_rdata alone.
            if (ack && state == BUSY_I)
                i_rdata_q <= mem_rdata;
            if (ack && state == BUSY_D && !mem_we)
                d_rdata_q <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts data wins that left a fetch waiting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (grant_i)
            starve_cnt <= '0;
        else if (grant_d && i_req && !starved)
            starve_cnt <= starve_cnt + SW'(1);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 64;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stall_f;
    logic        stall_m;
    logic        timeout_err;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; int lat; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } gnt_t;

    exp_t        iq[$];
    exp_t        dq[$];
    gnt_t        glog[$];
    logic [31:0] mem_model [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bk_delay = 1;
    bit          bk_en = 1'b1;
    bit          bk_spur = 1'b0;
    logic [31:0] last_d = 32'h0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Backend memory model: acks bk_delay cycles after mem_req is first seen.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0; cnt = 0;
            end else if (mem_req && bk_en) begin
                if (cnt == bk_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_rdata = 32'h7777_7777;
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = rd(mem_addr);
                    end
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF; cnt++;
                end
            end else begin
                mem_ack   = bk_spur;
                mem_rdata = bk_spur ? 32'hBAD0_0BAD : 32'h0;
                cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops, grant log, stall equations.
    initial begin
        int busy = 0;
        bit prev_req = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (mem_req) busy++;
            if (mem_req && !prev_req) glog.push_back('{mem_we, mem_addr, mem_wdata, cyc});
            prev_req = mem_req;
            n_chk++;
            if (i_valid && d_valid) begin
                n_fail++; $display("FAIL both_valid i_valid=%b d_valid=%b required not both 1", i_valid, d_valid);
            end
            n_chk++;
            if (stall_f !== (i_req & ~i_valid)) begin
                n_fail++; $display("FAIL stall_f got %b required %b", stall_f, i_req & ~i_valid);
            end
            n_chk++;
            if (stall_m !== (d_req & ~d_valid)) begin
                n_fail++; $display("FAIL stall_m got %b required %b", stall_m, d_req & ~d_valid);
            end
            if (i_valid) begin
                n_chk++;
                if (iq.size() == 0) begin
                    n_fail++; $display("FAIL i_spurious i_valid=1 required 0 (nothing outstanding)");
                end else begin
                    e = iq.pop_front();
                    if (i_rdata !== e.rdata) begin
                        n_fail++; $display("FAIL i_rdata got %h required %h", i_rdata, e.rdata);
                    end
                    if (e.lat >= 0) begin
                        n_chk++;
                        if (busy != e.lat) begin
                            n_fail++; $display("FAIL i_latency got %0d required %0d", busy, e.lat);
                        end
                    end
                end
            end
            if (d_valid) begin
                n_chk++;
                if (dq.size() == 0) begin
                    n_fail++; $display("FAIL d_spurious d_valid=1 required 0 (nothing outstanding)");
                end else begin
                    e = dq.pop_front();
                    if (d_rdata !== e.rdata) begin
                        n_fail++; $display("FAIL d_rdata got %h required %h", d_rdata, e.rdata);
                    end
                    if (e.lat >= 0) begin
                        n_chk++;
                        if (busy != e.lat) begin
                            n_fail++; $display("FAIL d_latency got %0d required %0d", busy, e.lat);
                        end
                    end
                end
            end
            if (!mem_req || i_valid || d_valid) busy = 0;
        end
    end

    task automatic do_i(input logic [31:0] addr, input logic [31:0] exp, input int lat);
        exp_t e;
        int k = 0;
        e.rdata = exp; e.lat = lat;
        iq.push_back(e);
        i_req = 1'b1; i_addr = addr;
        do begin @(negedge clk); #3; k++; end while (!i_valid && k < 300);
        if (!i_valid) begin
            n_chk++; n_fail++;
            $display("FAIL i_wait no i_valid for addr %h within 300 cycles", addr);
            void'(iq.pop_back());
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input int lat);
        exp_t e;
        int k = 0;
        e.rdata = exp; e.lat = lat;
        dq.push_back(e);
        if (!we) last_d = exp;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        do begin @(negedge clk); #3; k++; end while (!d_valid && k < 300);
        if (!d_valid) begin
            n_chk++; n_fail++;
            $display("FAIL d_wait no d_valid for addr %h within 300 cycles", addr);
            void'(dq.pop_back());
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        n_chk++; if (mem_req !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_req got %b required 0", mem_req); end
        n_chk++; if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL reset_mem_we got %b required 0", mem_we); end
        n_chk++; if (mem_addr !== 32'h0)   begin n_fail++; $display("FAIL reset_mem_addr got %h required 0", mem_addr); end
        n_chk++; if (mem_wdata !== 32'h0)  begin n_fail++; $display("FAIL reset_mem_wdata got %h required 0", mem_wdata); end
        n_chk++; if (i_rdata !== 32'h0)    begin n_fail++; $display("FAIL reset_i_rdata got %h required 0", i_rdata); end
        n_chk++; if (d_rdata !== 32'h0)    begin n_fail++; $display("FAIL reset_d_rdata got %h required 0", d_rdata); end
        n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b required 0", timeout_err); end
        n_chk++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b%b required 00", i_valid, d_valid);
        end
        rst_n = 1'b1;
        last_d = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read;
        mem_model[32'h0040_0000] = 32'h2408_0005;
        bk_delay = 1;
        fork
            do_i(32'h0040_0000, 32'h2408_0005, 2);
            begin
                @(negedge clk); #2;
                n_chk++; if (stall_f !== 1'b1) begin n_fail++; $display("FAIL single_stall_f got %b required 1", stall_f); end
                @(negedge clk); #2;
                n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL single_mem_req got %b required 1", mem_req); end
                n_chk++; if (mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL single_mem_addr got %h required 00400000", mem_addr); end
                n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_mem_we got %b required 0", mem_we); end
            end
        join
        @(negedge clk); #2;
        n_chk++; if (i_rdata !== 32'h2408_0005) begin n_fail++; $display("FAIL single_i_rdata_hold got %h required 24080005", i_rdata); end
        n_chk++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL single_i_valid_after got %b required 0", i_valid); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] ia;
        ia = 32'h0040_0008;
        bk_delay = 1;
        glog.delete();
        fork
            do_d(1'b1, 32'h1001_0000, 32'hCAFE_F00D, last_d, 2);
            do_i(ia, rd(ia), 2);
        join
        n_chk++;
        if (glog.size() != 2) begin
            n_fail++; $display("FAIL simul_grants got %0d grants required 2", glog.size());
        end else begin
            n_chk++;
            if (glog[0].we !== 1'b1 || glog[0].addr !== 32'h1001_0000 || glog[0].wdata !== 32'hCAFE_F00D) begin
                n_fail++; $display("FAIL simul_first_grant got we=%b addr=%h wdata=%h required we=1 addr=10010000 wdata=cafef00d",
                                   glog[0].we, glog[0].addr, glog[0].wdata);
            end
            n_chk++;
            if (glog[1].we !== 1'b0 || glog[1].addr !== ia) begin
                n_fail++; $display("FAIL simul_second_grant got we=%b addr=%h required we=0 addr=%h", glog[1].we, glog[1].addr, ia);
            end
            n_chk++;
            if (glog[1].cyc - glog[0].cyc != 3) begin
                n_fail++; $display("FAIL simul_gap got %0d cycles required 3", glog[1].cyc - glog[0].cyc);
            end
        end
    endtask

    task automatic test_starvation;
        logic [31:0] ia;
        ia = 32'h0040_000C;
        bk_delay = 0;
        glog.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    logic [31:0] a;
                    a = 32'h1001_0100 + 32'(4 * k);
                    do_d(1'b0, a, 32'h0, rd(a), 1);
                end
            end
            do_i(ia, rd(ia), 1);
        join
        n_chk++;
        if (glog.size() != 7) begin
            n_fail++; $display("FAIL starve_grants got %0d grants required 7", glog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (glog[k].addr !== 32'h1001_0100 + 32'(4 * k)) begin
                    n_fail++; $display("FAIL starve_d_grant%0d got %h required %h", k, glog[k].addr, 32'h1001_0100 + 32'(4 * k));
                end
            end
            n_chk++;
            if (glog[4].addr !== ia) begin
                n_fail++; $display("FAIL starve_i_grant got %h required %h", glog[4].addr, ia);
            end
            n_chk++;
            if (glog[5].addr !== 32'h1001_0110) begin
                n_fail++; $display("FAIL starve_resume got %h required 10010110", glog[5].addr);
            end
        end
        n_chk++;
        if (dut.starve_cnt !== '0) begin
            n_fail++; $display("FAIL starve_cnt_clear got %0d required 0", dut.starve_cnt);
        end
    endtask

    task automatic test_ack_boundary;
        mem_model[32'h1001_0200] = 32'h1234_5678;
        bk_delay = TIMEOUT - 1;
        do_d(1'b0, 32'h1001_0200, 32'h0, 32'h1234_5678, TIMEOUT);
        n_chk++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL boundary_timeout_err got %b required 0", timeout_err); end
    endtask

    task automatic test_timeout;
        logic [31:0] ia;
        ia = 32'h0040_0010;
        bk_en = 1'b0;
        do_d(1'b0, 32'h1001_0300, 32'h0, 32'hFFFF_FFFF, TIMEOUT);
        n_chk++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set got %b required 1", timeout_err); end
        bk_en = 1'b1;
        bk_delay = 1;
        do_i(ia, rd(ia), 2);
        n_chk++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky got %b required 1", timeout_err); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ia;
        int k = 0;
        bk_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h0040_0014;
        do begin @(negedge clk); #2; k++; end while (!mem_req && k < 10);
        n_chk++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got mem_req=%b required 1", mem_req); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req got %b required 0", mem_req); end
        n_chk++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_i_valid got %b required 0", i_valid); end
        n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout_err got %b required 0", timeout_err); end
        @(posedge clk); #1;
        i_req = 1'b0;
        last_d = 32'h0;
        @(negedge clk); #3 rst_n = 1'b1;
        bk_spur = 1'b1;
        repeat (2) begin
            @(negedge clk); #3;
            n_chk++;
            if (i_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL spurious_ack got i_valid=%b d_valid=%b mem_req=%b required 000", i_valid, d_valid, mem_req);
            end
        end
        bk_spur = 1'b0;
        bk_en = 1'b1;
        bk_delay = 2;
        @(posedge clk); #1;
        ia = 32'h0040_0018;
        do_i(ia, rd(ia), 3);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_ack_boundary();
        test_timeout();
        test_reset_mid();
        repeat (3) @(posedge clk);
        n_chk++;
        if (iq.size() != 0 || dq.size() != 0) begin
            n_fail++; $display("FAIL leftover_expected got i=%0d d=%0d required 0 0", iq.size(), dq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
